keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces key presses and emits one key code with a one-cycle strobe per press.

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/key_decode.sv | 33 +++
 rtl/keypad_scanner.sv | 185 ++++++++++++++++++
 tb/tb_keypad_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM state encoding, key codes
// and the row/column to key-code map.
// Latency: none (types, constants and pure functions only). Backpressure: n/a.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2
   } state_t;

   localparam logic [4:0] KEY_A    = 5'd10;
   localparam logic [4:0] KEY_B    = 5'd11;
   localparam logic [4:0] KEY_C    = 5'd12;
   localparam logic [4:0] KEY_D    = 5'd13;
   localparam logic [4:0] KEY_STAR = 5'd14;
   localparam logic [4:0] KEY_HASH = 5'd15;
   localparam logic [4:0] KEY_NONE = 5'd16;

   localparam logic [3:0] COL_FIRST = 4'b1110;
   localparam logic [3:0] ROW_IDLE  = 4'b1111;

   // Row r (top row = 0) and column c to key code.
   function automatic logic [4:0] key_of(input logic [1:0] r, input logic [1:0] c);
      logic [4:0] k;
      case ({r, c})
         4'h0: k = 5'd1;    4'h1: k = 5'd2;    4'h2: k = 5'd3;    4'h3: k = KEY_A;
         4'h4: k = 5'd4;    4'h5: k = 5'd5;    4'h6: k = 5'd6;    4'h7: k = KEY_B;
         4'h8: k = 5'd7;    4'h9: k = 5'd8;    4'hA: k = 5'd9;    4'hB: k = KEY_C;
         4'hC: k = KEY_STAR; 4'hD: k = 5'd0;   4'hE: k = KEY_HASH; default: k = KEY_D;
      endcase
      return k;
   endfunction

   // Next active-low column strobe: 1110 -> 1101 -> 1011 -> 0111 -> 1110.
   function automatic logic [3:0] col_next(input logic [3:0] c);
      return {c[2:0], c[3]};
   endfunction

endpackage

// File: rtl/key_decode.sv
// Combinational keypad decode: active-low row sample + active-low column strobe -> key code.
// Latency: 0 cycles. Backpressure: none (pure combinational).
// Ports: fila[3:0] rows (active low), col[3:0] driven column (one-hot low),
//        code[4:0] key code (KEY_NONE if no row low), multi = more than one row low.
module key_decode
   import keypad_pkg::*;
(
   input  logic [3:0] fila,
   input  logic [3:0] col,
   output logic [4:0] code,
   output logic       multi
);

   logic [2:0] n_low;
   logic [1:0] r_idx;
   logic [1:0] c_idx;

   always_comb begin
      n_low = '0;
      r_idx = '0;
      c_idx = '0;
      for (int i = 0; i < 4; i++) begin
         if (!fila[i]) begin
            n_low = n_low + 3'd1;
            r_idx = 2'(i);
         end
         if (!col[i]) c_idx = 2'(i);
      end
      multi = (n_low > 3'd1);
      code  = (n_low == 3'd0) ? KEY_NONE : key_of(r_idx, c_idx);
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce; one digito/cambio_digito strobe per accepted press.
// Latency: 2-cycle input synchroniser, strobe one cycle after the DEBOUNCE_SCANS-th matching sample.
// Backpressure: none; the downstream memory must take every strobe (strobes are >= SCAN_DIV apart).
// Ports: clk, rst_n (async, active low), fila[3:0] rows in (active low, async),
//        col[3:0] column drive (one-hot low), digito[4:0] last key (16 = none), cambio_digito strobe.
// Option: define KEY_REPEAT_EN for auto-repeat of a held key every REPEAT_SCANS samples.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50_000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 250
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] fila,
   output logic [3:0] col,
   output logic [4:0] digito,
   output logic       cambio_digito
);

   localparam int            TW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [TW-1:0] TMR_LAST  = TW'(SCAN_DIV - 1);
   localparam int            CW        = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] DB_TARGET = CW'(DEBOUNCE_SCANS);

   logic [3:0]    fila_m, fila_s;
   logic [TW-1:0] tmr_q;
   logic          sample;

   state_t        state_q, state_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    row_q, row_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic [4:0]    digito_q, digito_d;
   logic          stb_q, stb_d;
   logic          accept;

   logic [4:0]    key_code;
   logic          key_multi;

   // Rows idle high through the synchroniser so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fila_m <= ROW_IDLE;
         fila_s <= ROW_IDLE;
      end else begin
         fila_m <= fila;
         fila_s <= fila_m;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      tmr_q <= '0;
      else if (sample) tmr_q <= '0;
      else             tmr_q <= tmr_q + 1'b1;
   end
   assign sample = (tmr_q == TMR_LAST);

   key_decode u_key_decode (
      .fila  (fila_s),
      .col   (col_q),
      .code  (key_code),
      .multi (key_multi)
   );

`ifdef KEY_REPEAT_EN
   localparam int            RW       = $clog2(REPEAT_SCANS + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
   logic [RW-1:0] rep_q, rep_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rep_q <= '0;
      else        rep_q <= rep_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SCAN;
         col_q    <= COL_FIRST;
         row_q    <= ROW_IDLE;
         cnt_q    <= '0;
         digito_q <= KEY_NONE;
         stb_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         col_q    <= col_d;
         row_q    <= row_d;
         cnt_q    <= cnt_d;
         digito_q <= digito_d;
         stb_q    <= stb_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      col_d    = col_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      digito_d = digito_q;
      stb_d    = 1'b0;
      accept   = 1'b0;
      cnt_inc  = cnt_q + 1'b1;
`ifdef KEY_REPEAT_EN
      rep_d    = rep_q;
`endif
      case (state_q)
         SCAN: begin
            if (sample) begin
               if (fila_s == ROW_IDLE) begin
                  col_d = col_next(col_q);
               end else begin
                  row_d   = fila_s;
                  cnt_d   = CW'(1);
                  state_d = DEBOUNCE;
                  // A single required sample means this detection is already the accept.
                  if (DEBOUNCE_SCANS == 1) accept = 1'b1;
               end
            end
         end
         DEBOUNCE: begin
            if (sample) begin
               if (fila_s == row_q) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == DB_TARGET) accept = 1'b1;
               end else begin
                  state_d = SCAN;
                  col_d   = col_next(col_q);
                  cnt_d   = '0;
               end
            end
         end
         PRESSED: begin
            if (sample) begin
               if (fila_s == ROW_IDLE) begin
                  if (cnt_inc == DB_TARGET) begin
                     state_d = SCAN;
                     col_d   = col_next(col_q);
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
`ifdef KEY_REPEAT_EN
               // Repeat only while the row pattern is exactly the one accepted.
               if (fila_s == row_q) begin
                  if (rep_q == REP_LAST) begin
                     rep_d = '0;
                     stb_d = 1'b1;
                  end else begin
                     rep_d = rep_q + 1'b1;
                  end
               end else begin
                  rep_d = '0;
               end
`endif
            end
         end
         default: state_d = SCAN;
      endcase

      // Stable pattern: a single row is a key, several rows are a ghost and dropped.
      if (accept) begin
         cnt_d = '0;
`ifdef KEY_REPEAT_EN
         rep_d = '0;
`endif
         if (!key_multi) begin
            digito_d = key_code;
            stb_d    = 1'b1;
            state_d  = PRESSED;
         end else begin
            state_d  = SCAN;
         end
      end
   end

   assign col           = col_q;
   assign digito        = digito_q;
   assign cambio_digito = stb_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5.
// Samples are every 4 clk; a press settled right after a column change strobes 12 cycles later.
// Outputs are observed on the falling edge; inputs change on the falling edge.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] fila;
   logic [3:0] col;
   logic [4:0] digito;
   logic       cambio_digito;

   int n_checks = 0;
   int n_fail   = 0;

   int         nstb;
   int         first_stb;
   logic [4:0] last_dig;
   int         b2b;

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (3),
      .REPEAT_SCANS   (5)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .fila          (fila),
      .col           (col),
      .digito        (digito),
      .cambio_digito (cambio_digito)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Run n cycles, recording strobes; iteration i observes the state after the i-th rising edge.
   task automatic run(input int n);
      logic prev;
      nstb      = 0;
      first_stb = 0;
      b2b       = 0;
      prev      = 1'b0;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (cambio_digito === 1'b1) begin
            nstb++;
            if (first_stb == 0) first_stb = i;
            last_dig = digito;
            if (prev) b2b++;
         end
         prev = (cambio_digito === 1'b1);
      end
   endtask

   // Wait (bounded) until the DUT drives the given column; a timeout counts as a failure.
   task automatic wait_col(input logic [3:0] target, input string tag);
      int k;
      k = 0;
      while (col !== target && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (col !== target) chk(tag, col, target);
   endtask

   initial begin
      last_dig = 5'd31;
      fila  = 4'b1111;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_col", col, 4'b1110);
      chk("reset_digito", digito, 5'd16);
      chk("reset_strobe", cambio_digito, 1'b0);
      rst_n = 1'b1;

      // 1: idle scanning, column changes every 4 clk
      run(3);
      chk("scan_hold_1110", col, 4'b1110);
      run(1);
      chk("scan_1101", col, 4'b1101);
      run(4);
      chk("scan_1011", col, 4'b1011);
      run(4);
      chk("scan_0111", col, 4'b0111);
      run(4);
      chk("scan_wrap_1110", col, 4'b1110);
      chk("scan_digito", digito, 5'd16);

      // 2: hold "5" (row1, col1)
      wait_col(4'b1101, "wait_col_5");
      fila = 4'b1101;
      run(16);
      chk("k5_strobes", nstb, 1);
      chk("k5_strobe_time", first_stb, 12);
      chk("k5_digito", last_dig, 5'd5);
      chk("k5_col_frozen", col, 4'b1101);
      chk("k5_no_b2b", b2b, 0);
      fila = 4'b1111;
      run(12);
      chk("k5_release_col", col, 4'b1011);
      chk("k5_release_strobes", nstb, 0);

      // 3: "7" (row2, col0) bounces after two samples
      wait_col(4'b1110, "wait_col_7");
      fila = 4'b1011;
      run(8);
      fila = 4'b1111;
      run(4);
      chk("bounce_col", col, 4'b1101);
      chk("bounce_strobes", nstb, 0);
      chk("bounce_digito", digito, 5'd5);

      // 4: "#" and "9" together in column 2 (rows 3 and 2)
      wait_col(4'b1011, "wait_col_ghost");
      fila = 4'b0011;
      run(16);
      chk("ghost_strobes", nstb, 0);
      chk("ghost_digito", digito, 5'd5);
      fila = 4'b1111;
      run(8);

      // 5: "1", extra key while held, release, then "D"
      wait_col(4'b1110, "wait_col_1");
      fila = 4'b1110;
      run(16);
      chk("k1_strobes", nstb, 1);
      chk("k1_strobe_time", first_stb, 12);
      chk("k1_digito", last_dig, 5'd1);
      fila = 4'b1100;
      run(16);
      chk("k1_second_key_strobes", nstb, 0);
      chk("k1_second_key_col", col, 4'b1110);
      fila = 4'b1111;
      run(12);
      chk("k1_release_col", col, 4'b1101);
      wait_col(4'b0111, "wait_col_D");
      fila = 4'b0111;
      run(16);
      chk("kD_strobes", nstb, 1);
      chk("kD_digito", last_dig, 5'd13);
      chk("kD_digito_hold", digito, 5'd13);
      fila = 4'b1111;
      run(12);
      chk("kD_release_col", col, 4'b1110);

      // 6: reset in the middle of debouncing "2" (row0, col1)
      wait_col(4'b1101, "wait_col_2");
      fila = 4'b1110;
      run(6);
      chk("k2_pre_reset_strobes", nstb, 0);
      rst_n = 1'b0;
      #1;
      chk("midreset_digito", digito, 5'd16);
      chk("midreset_col", col, 4'b1110);
      chk("midreset_strobe", cambio_digito, 1'b0);
      fila = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(16);
      chk("post_reset_strobes", nstb, 0);
      chk("post_reset_digito", digito, 5'd16);

      // Hold "0" (row3, col1) for a long time
      wait_col(4'b1101, "wait_col_0");
      fila = 4'b0111;
      run(56);
      chk("k0_first_time", first_stb, 12);
      chk("k0_digito", last_dig, 5'd0);
      chk("k0_no_b2b", b2b, 0);
`ifdef KEY_REPEAT_EN
      chk("k0_repeat_strobes", nstb, 3);
`else
      chk("k0_single_strobe", nstb, 1);
`endif
      fila = 4'b1111;
      run(12);
      chk("k0_release_col", col, 4'b1011);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
